// File: rtl/vga_timing_pkg.sv
// Mode constant sets and total-span helpers for the VGA raster timing generator.
package vga_timing_pkg;

    typedef struct packed {
        int   h_active;
        int   h_fp;
        int   h_sync;
        int   h_bp;
        int   v_active;
        int   v_fp;
        int   v_sync;
        int   v_bp;
        logic h_pol;
        logic v_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_800X600_72 = '{
        h_active: 800, h_fp: 56, h_sync: 120, h_bp: 64,
        v_active: 600, v_fp: 37, v_sync: 6,   v_bp: 23,
        h_pol: 1'b1, v_pol: 1'b1
    };

    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        h_pol: 1'b0, v_pol: 1'b0
    };

    function automatic int span_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input vga_mode_t m);
        return span_total(m.h_active, m.h_fp, m.h_sync, m.h_bp);
    endfunction

    function automatic int v_total(input vga_mode_t m);
        return span_total(m.v_active, m.v_fp, m.v_sync, m.v_bp);
    endfunction

endpackage

// File: rtl/pix_clk_div.sv
// Divides the system clock into a one-clk pixel strobe every PIX_DIV clocks.
module pix_clk_div #(
    parameter int PIX_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pix_tick
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    if (PIX_DIV < 1) begin : g_div_chk
        $error("PIX_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_cnt;
    logic             tick_q;

    // tick_q holds its phase while en is low so a paused raster resumes exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            tick_q  <= 1'b0;
        end else if (en) begin
            tick_q  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    assign pix_tick = tick_q & en;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, h/v raster counters and registered
// sync/blank/coordinate decode aligned with the counters.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = MODE_800X600_72.h_active,
    parameter int H_FP     = MODE_800X600_72.h_fp,
    parameter int H_SYNC   = MODE_800X600_72.h_sync,
    parameter int H_BP     = MODE_800X600_72.h_bp,
    parameter int V_ACTIVE = MODE_800X600_72.v_active,
    parameter int V_FP     = MODE_800X600_72.v_fp,
    parameter int V_SYNC   = MODE_800X600_72.v_sync,
    parameter int V_BP     = MODE_800X600_72.v_bp,
    parameter bit H_POL    = MODE_800X600_72.h_pol,
    parameter bit V_POL    = MODE_800X600_72.v_pol,
    parameter int PIX_DIV  = 1,
    parameter int CNT_W    = 11,
    parameter int FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               pix_tick,
    output logic [CNT_W-1:0]   pix_x,
    output logic [CNT_W-1:0]   pix_y,
    output logic               h_sync,
    output logic               v_sync,
    output logic               draw_active,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_total_chk
        $error("H_TOTAL/V_TOTAL exceed the CNT_W counter range");
    end
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_porch_chk
        $error("porch and sync widths must be at least 1");
    end

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SY_B  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SY_E  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SY_B  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SY_E  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    pix_clk_div #(.PIX_DIV(PIX_DIV)) u_div (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pix_tick (pix_tick)
    );

    logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic             h_wrap, v_wrap, act_nxt, hs_nxt, vs_nxt;
    logic             first_q, ls_q, fs_q;

    always_comb begin
        h_wrap  = (h_cnt == H_LAST);
        v_wrap  = (v_cnt == V_LAST);
        h_nxt   = h_wrap ? '0 : h_cnt + CNT_W'(1);
        v_nxt   = v_cnt;
        if (h_wrap)
            v_nxt = v_wrap ? '0 : v_cnt + CNT_W'(1);
        act_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hs_nxt  = (h_nxt >= H_SY_B && h_nxt < H_SY_E) ? H_POL : !H_POL;
        vs_nxt  = (v_nxt >= V_SY_B && v_nxt < V_SY_E) ? V_POL : !V_POL;
    end

    // first_q suppresses the frame count on the wrap out of the reset position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            first_q     <= 1'b1;
            frame_cnt   <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            draw_active <= 1'b0;
            h_sync      <= !H_POL;
            v_sync      <= !V_POL;
            ls_q        <= 1'b0;
            fs_q        <= 1'b0;
        end else if (pix_tick) begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            first_q     <= 1'b0;
            if (h_wrap && v_wrap && !first_q)
                frame_cnt <= frame_cnt + FRAME_W'(1);
            pix_x       <= act_nxt ? h_nxt : '0;
            pix_y       <= act_nxt ? v_nxt : '0;
            draw_active <= act_nxt;
            h_sync      <= hs_nxt;
            v_sync      <= vs_nxt;
            ls_q        <= h_wrap;
            fs_q        <= h_wrap && v_wrap;
        end else begin
            ls_q        <= 1'b0;
            fs_q        <= 1'b0;
        end
    end

    assign line_start  = ls_q & en;
    assign frame_start = fs_q & en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small-mode vector table plus pause, async reset,
// divider, polarity and default-mode line sequences.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        tick;
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        da;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
    } obs_t;

    typedef struct {
        int   n;
        obs_t e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;
    logic en_a = 1'b1, en_b = 1'b1, en_c = 1'b1, en_d = 1'b1;

    logic        tick_a, hs_a, vs_a, da_a, ls_a, fs_a;
    logic [10:0] x_a, y_a;
    logic [7:0]  fc_a;
    logic        tick_b, hs_b, vs_b, da_b, ls_b, fs_b;
    logic [10:0] x_b, y_b;
    logic [7:0]  fc_b;
    logic        tick_c, hs_c, vs_c, da_c, ls_c, fs_c;
    logic [10:0] x_c, y_c;
    logic [7:0]  fc_c;
    logic        tick_d, hs_d, vs_d, da_d, ls_d, fs_d;
    logic [10:0] x_d, y_d;
    logic [7:0]  fc_d;

    obs_t obs_a, obs_b, obs_c, obs_d;
    assign obs_a = {tick_a, x_a, y_a, hs_a, vs_a, da_a, ls_a, fs_a, fc_a};
    assign obs_b = {tick_b, x_b, y_b, hs_b, vs_b, da_b, ls_b, fs_b, fc_b};
    assign obs_c = {tick_c, x_c, y_c, hs_c, vs_c, da_c, ls_c, fs_c, fc_c};
    assign obs_d = {tick_d, x_d, y_d, hs_d, vs_d, da_d, ls_d, fs_d, fc_d};

    // Small mode: H 8/2/2/2 (14 total), V 4/1/1/1 (7 total).
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .PIX_DIV(1)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .pix_tick(tick_a), .pix_x(x_a), .pix_y(y_a),
        .h_sync(hs_a), .v_sync(vs_a), .draw_active(da_a), .line_start(ls_a),
        .frame_start(fs_a), .frame_cnt(fc_a));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .PIX_DIV(3)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .pix_tick(tick_b), .pix_x(x_b), .pix_y(y_b),
        .h_sync(hs_b), .v_sync(vs_b), .draw_active(da_b), .line_start(ls_b),
        .frame_start(fs_b), .frame_cnt(fc_b));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(1), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0), .PIX_DIV(1)) dut_c (
        .clk(clk), .rst(rst_c), .en(en_c), .pix_tick(tick_c), .pix_x(x_c), .pix_y(y_c),
        .h_sync(hs_c), .v_sync(vs_c), .draw_active(da_c), .line_start(ls_c),
        .frame_start(fs_c), .frame_cnt(fc_c));

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst_d), .en(en_d), .pix_tick(tick_d), .pix_x(x_d), .pix_y(y_d),
        .h_sync(hs_d), .v_sync(vs_d), .draw_active(da_d), .line_start(ls_d),
        .frame_start(fs_d), .frame_cnt(fc_d));

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t mk(input logic t, input int x, input int y, input logic hs,
                                input logic vs, input logic da, input logic ls,
                                input logic fs, input int fc);
        obs_t o;
        o.tick = t;  o.x = 11'(x);  o.y = 11'(y);
        o.hs = hs;   o.vs = vs;     o.da = da;
        o.ls = ls;   o.fs = fs;     o.fc = 8'(fc);
        return o;
    endfunction

    vec_t va[$];
    obs_t rst_obs;
    obs_t hold_obs;

    initial begin
        int cyc;
        int ls_cnt, fs_cnt, da_cnt, hs_cnt;

        // n = clk edges since rst release; raster reaches (0,0) on edge 2.
        va.push_back('{n:0,   e:mk(0,0,0,0,0,0,0,0,0)});
        va.push_back('{n:1,   e:mk(1,0,0,0,0,0,0,0,0)});
        va.push_back('{n:2,   e:mk(1,0,0,0,0,1,1,1,0)});
        va.push_back('{n:3,   e:mk(1,1,0,0,0,1,0,0,0)});
        va.push_back('{n:9,   e:mk(1,7,0,0,0,1,0,0,0)});
        va.push_back('{n:10,  e:mk(1,0,0,0,0,0,0,0,0)});
        va.push_back('{n:12,  e:mk(1,0,0,1,0,0,0,0,0)});
        va.push_back('{n:13,  e:mk(1,0,0,1,0,0,0,0,0)});
        va.push_back('{n:14,  e:mk(1,0,0,0,0,0,0,0,0)});
        va.push_back('{n:16,  e:mk(1,0,1,0,0,1,1,0,0)});
        va.push_back('{n:17,  e:mk(1,1,1,0,0,1,0,0,0)});
        va.push_back('{n:50,  e:mk(1,6,3,0,0,1,0,0,0)});
        va.push_back('{n:58,  e:mk(1,0,0,0,0,0,1,0,0)});
        va.push_back('{n:72,  e:mk(1,0,0,0,1,0,1,0,0)});
        va.push_back('{n:82,  e:mk(1,0,0,1,1,0,0,0,0)});
        va.push_back('{n:86,  e:mk(1,0,0,0,0,0,1,0,0)});
        va.push_back('{n:99,  e:mk(1,0,0,0,0,0,0,0,0)});
        va.push_back('{n:100, e:mk(1,0,0,0,0,1,1,1,1)});
        va.push_back('{n:101, e:mk(1,1,0,0,0,1,0,0,1)});
        va.push_back('{n:151, e:mk(1,0,0,0,0,0,0,0,1)});
        rst_obs = mk(0,0,0,0,0,0,0,0,0);

        // ---- dut_a: vector table ----
        step(); step();
        rst_a = 1'b0;
        cyc = 0; ls_cnt = 0; fs_cnt = 0;
        foreach (va[i]) begin
            while (cyc < va[i].n) begin
                step();
                cyc++;
                if (cyc >= 2 && cyc <= 99) begin
                    ls_cnt += int'(obs_a.ls);
                    fs_cnt += int'(obs_a.fs);
                end
            end
            check($sformatf("vec_a n=%0d", va[i].n), 64'(obs_a), 64'(va[i].e));
        end
        check("line_start per frame", 64'(ls_cnt), 64'(7));
        check("frame_start per frame", 64'(fs_cnt), 64'(1));

        // ---- dut_a: async reset at (9,3) of frame 2, between edges ----
        #2 rst_a = 1'b1;
        #1 check("async rst outputs", 64'(obs_a), 64'(rst_obs));
        step(); step();
        rst_a = 1'b0;
        step();
        check("post rst n=1", 64'(obs_a), 64'(mk(1,0,0,0,0,0,0,0,0)));
        step();
        check("post rst n=2", 64'(obs_a), 64'(mk(1,0,0,0,0,1,1,1,0)));

        // ---- dut_a: pause at (5,2) for 20 clocks ----
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        for (int n = 1; n <= 35; n++) step();
        check("at (5,2)", 64'(obs_a), 64'(mk(1,5,2,0,0,1,0,0,0)));
        en_a = 1'b0;
        hold_obs = mk(0,5,2,0,0,1,0,0,0);
        #1 check("en low immediate", 64'(obs_a), 64'(hold_obs));
        for (int n = 0; n < 20; n++) begin
            step();
            check($sformatf("en hold %0d", n), 64'(obs_a), 64'(hold_obs));
        end
        en_a = 1'b1;
        step();
        check("resume (6,2)", 64'(obs_a), 64'(mk(1,6,2,0,0,1,0,0,0)));
        step();
        check("resume (7,2)", 64'(obs_a), 64'(mk(1,7,2,0,0,1,0,0,0)));
        rst_a = 1'b1;

        // ---- dut_b: PIX_DIV=3, tick every 3rd clk, raster moves on edges 4,7,10,... ----
        check("div3 reset", 64'(obs_b), 64'(rst_obs));
        rst_b = 1'b0;
        for (int n = 1; n <= 130; n++) begin
            int p, h, ex;
            logic et, el, ef;
            step();
            et = (n % 3 == 0);
            ex = 0; el = 1'b0; ef = 1'b0;
            if (n >= 4) begin
                p  = (n - 4) / 3;
                h  = p % 14;
                ex = (h < 8 && p / 14 < 4) ? h : 0;
                el = ((n - 4) % 42 == 0);
                ef = (n == 4);
            end
            check($sformatf("div3 n=%0d tick/x/ls/fs", n),
                  64'({obs_b.tick, obs_b.x, obs_b.ls, obs_b.fs}),
                  64'({et, 11'(ex), el, ef}));
        end
        rst_b = 1'b1;

        // ---- dut_c: active-low syncs ----
        check("pol0 reset syncs", 64'({obs_c.hs, obs_c.vs}), 64'(2'b11));
        rst_c = 1'b0;
        step();
        for (int n = 2; n <= 99; n++) begin
            int p, h, v;
            step();
            p = n - 2; h = p % 14; v = p / 14;
            check($sformatf("pol0 n=%0d syncs", n), 64'({obs_c.hs, obs_c.vs}),
                  64'({!(h == 10 || h == 11), !(v == 5)}));
        end
        rst_c = 1'b1;

        // ---- dut_d: default 800x600 mode, first line ----
        check("default reset", 64'(obs_d), 64'(rst_obs));
        rst_d = 1'b0;
        da_cnt = 0; hs_cnt = 0; ls_cnt = 0;
        for (int n = 1; n <= 1042; n++) begin
            step();
            if (n >= 2 && n <= 1041) begin
                da_cnt += int'(obs_d.da);
                hs_cnt += int'(obs_d.hs);
            end
            if (n >= 2) ls_cnt += int'(obs_d.ls);
            if (n == 801) check("default x=799", 64'(obs_d.x), 64'(799));
            if (n == 857) check("default hs before sync", 64'(obs_d.hs), 64'(0));
            if (n == 858) check("default hs sync start", 64'(obs_d.hs), 64'(1));
            if (n == 1042) check("default line 1 start", 64'({obs_d.ls, obs_d.y, obs_d.x}),
                                 64'({1'b1, 11'd1, 11'd0}));
        end
        check("default active per line", 64'(da_cnt), 64'(800));
        check("default hsync per line", 64'(hs_cnt), 64'(120));
        check("default line_starts", 64'(ls_cnt), 64'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: the successor to the fixed-mode pixel iterator, sitting between the system clock and the pixel-colour logic of the screen design. It divides the system clock into a pixel-rate strobe, walks a horizontal/vertical raster with programmable porches, sync widths and sync polarity, and emits registered sync, blanking, coordinate, line/frame-start and frame-count outputs. Downstream drawing logic consumes `pix_x`/`pix_y`/`draw_active` and must act on the same `pix_tick`.

## Interface
- `H_ACTIVE`, 800: visible pixels per line
- `H_FP`, 56: horizontal front porch in pixels
- `H_SYNC`, 120: horizontal sync width in pixels
- `H_BP`, 64: horizontal back porch in pixels
- `V_ACTIVE`, 600: visible lines per frame
- `V_FP`, 37: vertical front porch in lines
- `V_SYNC`, 6: vertical sync width in lines
- `V_BP`, 23: vertical back porch in lines
- `H_POL`, 1: active level of `h_sync` (1 means active high)
- `V_POL`, 1: active level of `v_sync`
- `PIX_DIV`, 1: system clocks per pixel; must be at least 1
- `CNT_W`, 11: counter and coordinate width
- `FRAME_W`, 8: frame counter width
- `clk` in 1: system clock; all logic is on the rising edge
- `rst` in 1: asynchronous reset, active high
- `en` in 1: run enable; when low, the divider and raster freeze
- `pix_tick` out 1: one-`clk` strobe marking each pixel advance
- `pix_x` out CNT_W: horizontal position in the active area, otherwise 0
- `pix_y` out CNT_W: vertical position in the active area, otherwise 0
- `h_sync` out 1: horizontal sync at polarity `H_POL`
- `v_sync` out 1: vertical sync at polarity `V_POL`
- `draw_active` out 1: high while the current pixel is visible
- `line_start` out 1: one-`clk` pulse on the first pixel of every line
- `frame_start` out 1: one-`clk` pulse on pixel (0,0)
- `frame_cnt` out FRAME_W: number of completed frames, wrapping modulo 2^FRAME_W

## Operation
- Derived constants: `H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP` and `V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP`.
- Horizontal order within a line: active region, then front porch, then sync, then back porch. Vertical order within a frame follows the same pattern.
- Divider:
  - `div_cnt` counts from 0 to `PIX_DIV-1` while `en` is high.
  - `pix_tick` is registered. It is 1 for one `clk` in every `PIX_DIV` clocks.
  - With `PIX_DIV=1`, `pix_tick` stays high continuously while `en` is high.
- Raster counters `h_cnt` and `v_cnt` advance only on an edge where `pix_tick` is 1:
  - `h_cnt` wraps from `H_TOTAL-1` to 0.
  - `v_cnt` increments only when `h_cnt` wraps, and itself wraps from `V_TOTAL-1` to 0.
  - `frame_cnt` increments when both counters wrap together.
- All outputs are registered decodes of the next counter values, so they stay aligned with the counters:
  - `draw_active` is high when `h_cnt < H_ACTIVE` and `v_cnt < V_ACTIVE`.
  - `h_sync` equals `H_POL` when `H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC`, and `!H_POL` otherwise.
  - `v_sync` uses the same rule with the vertical constants and `V_POL`.
  - `pix_x` and `pix_y` equal `h_cnt` and `v_cnt` when `draw_active` is high, and 0 otherwise.
- Reset state:
  - The raster sits at position (`H_TOTAL-1`, `V_TOTAL-1`); `div_cnt` is 0.
  - `pix_x`=0, `pix_y`=0, `draw_active`=0.
  - `h_sync`=`!H_POL`, `v_sync`=`!V_POL`.
  - `pix_tick`, `line_start`, `frame_start` are 0, and `frame_cnt` is 0.
  - `frame_cnt` is not incremented by the first transition out of reset.
- `en` low: `div_cnt`, the counters and all level outputs hold their values. `pix_tick`, `line_start` and `frame_start` are forced to 0.
- `rst` asserted mid-frame: all state clears immediately, without waiting for a clock. After `rst` is released, the raster restarts cleanly at (0,0).
- Elaboration-time checks, which fail the build if violated:
  - `H_TOTAL` and `V_TOTAL` must each be at most 2^CNT_W.
  - Every porch and sync parameter must be at least 1.

## Timing
- The first `pix_tick` edge after reset moves the raster to (0,0). On the following `clk`:
  - `draw_active`=1, `line_start`=1, `frame_start`=1.
  - `frame_cnt` is still 0.
- Counter update to output valid: zero extra latency, because outputs change on the same edge as `h_cnt`/`v_cnt`.
- Each pixel position is held for exactly `PIX_DIV` clocks while `en` is high.
- `line_start` and `frame_start` are high for exactly one `clk`, never `PIX_DIV` clocks.
- `frame_cnt` increments on the same edge where `frame_start` rises, except on the first frame after reset.
- `en` deasserted and later reasserted: the timing phase resumes exactly where it stopped, with no skipped or repeated pixel.

## Structure
- Package `vga_timing_pkg` holds the mode constants as a set per mode:
  - 800x600@72 (defaults above).
  - 640x480@60: 640/16/96/48 horizontal, 480/10/2/33 vertical, both polarities 0.
  - It also holds functions computing `H_TOTAL` and `V_TOTAL`.
- Sub-module `pix_clk_div` implements the divider: inputs `clk`, `rst`, `en`; output `pix_tick`; parameter `PIX_DIV`.
- The top level holds the raster counters and the output decode.

## Test plan
- Small mode (H 8/2/2/2, V 4/1/1/1, `PIX_DIV`=1, both polarities 1), release `rst` -> `frame_start` at clk 1; `h_sync` high for h_cnt 10–11; `line_start` every 14 clocks; `frame_cnt` reads 1 after 98 clocks.
- Same mode with `PIX_DIV`=3 -> `pix_tick` every 3rd clk; each `pix_x` value held 3 clocks; `line_start` width 1 clk, period 42 clocks.
- `H_POL`=0, `V_POL`=0 -> during reset `h_sync`=1 and `v_sync`=1; `h_sync`=0 only for h_cnt 10–11; `v_sync`=0 only on line 5.
- Drop `en` for 20 clocks at (5,2) -> all outputs hold and there are no pulses; after `en` returns, the next pixel is (6,2).
- Assert `rst` asynchronously at (9,3) between clock edges -> outputs reach reset values before the next edge; the sequence restarts at (0,0) with `frame_cnt`=0.
- Default 800x600 mode over 2 frames -> `draw_active` count equals 480000 per frame; `v_sync` lines are 637–642; `frame_cnt` increments once per 692640 ticks.
